// File: rtl/iq_pkg.sv
// Shared issue-queue sizing constants, used by the allocation controller,
// the issue queue storage and the select arbiter.
package iq_pkg;
  localparam int unsigned DECODE_NUM = 4;
  localparam int unsigned ISSUE_NUM  = 4;
  localparam int unsigned CIQ_DEPTH  = 16;
  localparam int unsigned AGE        = 5;
  localparam int unsigned IDX_W      = $clog2(CIQ_DEPTH);
  localparam int unsigned CNT_W      = $clog2(CIQ_DEPTH + 1);

  typedef logic [IDX_W-1:0] iq_idx_t;
endpackage

// File: rtl/iq_free_picker.sv
// Combinational scan of the busy bitmap: the first NUM free entry indices in
// ascending order, with a valid bit each, plus the total free-entry count.
module iq_free_picker
  import iq_pkg::*;
#(
  parameter int unsigned NUM   = DECODE_NUM,
  parameter int unsigned DEPTH = CIQ_DEPTH,
  parameter int unsigned IW    = IDX_W,
  parameter int unsigned CW    = CNT_W
) (
  input  logic [DEPTH-1:0]        i_busy,
  output logic [NUM-1:0][IW-1:0]  o_idx,
  output logic [NUM-1:0]          o_vld,
  output logic [CW-1:0]           o_free_cnt
);

  logic [CW-1:0] w_seen;

  always_comb begin
    o_idx  = '0;
    o_vld  = '0;
    w_seen = '0;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      if (!i_busy[e]) begin
        // constant-index compare keeps the write port select lint-clean
        for (int unsigned k = 0; k < NUM; k++) begin
          if (w_seen == CW'(k)) begin
            o_idx[k] = IW'(e);
            o_vld[k] = 1'b1;
          end
        end
        w_seen = w_seen + CW'(1);
      end
    end
    o_free_cnt = w_seen;
  end

endmodule

// File: rtl/issue_queue_alloc_ctrl.sv
// Centralized issue-queue entry allocator: all-or-nothing dispatch into the
// lowest free entries, age tagging, and release on arbiter grants.
module issue_queue_alloc_ctrl #(
  parameter int unsigned DECODE_NUM = iq_pkg::DECODE_NUM,
  parameter int unsigned ISSUE_NUM  = iq_pkg::ISSUE_NUM,
  parameter int unsigned CIQ_DEPTH  = iq_pkg::CIQ_DEPTH,
  parameter int unsigned AGE        = iq_pkg::AGE
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [DECODE_NUM-1:0]                    dispatch_req,
  input  logic                                     flush,
  input  logic [ISSUE_NUM-1:0][iq_pkg::IDX_W-1:0]  arbit_addr,
  input  logic [ISSUE_NUM-1:0]                     arbit_grant,
  output logic [DECODE_NUM-1:0][iq_pkg::IDX_W-1:0] free_addr,
  output logic [DECODE_NUM-1:0]                    free_valid,
  output logic [DECODE_NUM-1:0][AGE-1:0]           age,
  output logic                                     dispatch_stall,
  output logic [4:0]                               iq_count,
  output logic                                     iq_full,
  output logic                                     iq_empty
);

  localparam int unsigned IW = iq_pkg::IDX_W;
  localparam int unsigned CW = 5;

  logic [CIQ_DEPTH-1:0]         r_busy;
  logic [AGE-1:0]               r_age_cnt;
  logic [CIQ_DEPTH-1:0]         w_busy_nxt;
  logic [AGE-1:0]               w_age_nxt;
  logic [DECODE_NUM-1:0][IW-1:0] w_pick_idx;
  logic [DECODE_NUM-1:0]        w_pick_vld;
  logic [CW-1:0]                w_free_cnt;
  logic [CW-1:0]                w_req_cnt;
  logic [CW-1:0]                w_rank;
  logic                         w_accept;

  iq_free_picker #(
    .NUM   (DECODE_NUM),
    .DEPTH (CIQ_DEPTH),
    .IW    (IW),
    .CW    (CW)
  ) u_picker (
    .i_busy     (r_busy),
    .o_idx      (w_pick_idx),
    .o_vld      (w_pick_vld),
    .o_free_cnt (w_free_cnt)
  );

  always_comb begin
    w_req_cnt = '0;
    for (int unsigned i = 0; i < DECODE_NUM; i++)
      w_req_cnt = w_req_cnt + CW'(dispatch_req[i]);
    // same-cycle releases are not counted as free: picker sees r_busy only
    w_accept       = rst_n & ~flush & (w_req_cnt <= w_free_cnt);
    dispatch_stall = flush | ((|dispatch_req) & ~w_accept);
  end

  always_comb begin
    free_addr  = '0;
    free_valid = '0;
    age        = '0;
    w_rank     = '0;
    for (int unsigned i = 0; i < DECODE_NUM; i++) begin
      age[i] = r_age_cnt + AGE'(w_rank);
      if (dispatch_req[i]) begin
        for (int unsigned k = 0; k < DECODE_NUM; k++) begin
          if (w_rank == CW'(k)) begin
            free_addr[i]  = w_pick_idx[k];
            free_valid[i] = w_accept & w_pick_vld[k];
          end
        end
      end
      w_rank = w_rank + CW'(dispatch_req[i]);
    end
  end

  always_comb begin
    w_busy_nxt = r_busy;
    w_age_nxt  = r_age_cnt;
    // release before allocate: a grant aimed at a free entry must not undo
    // that entry's allocation in the same cycle
    for (int unsigned j = 0; j < ISSUE_NUM; j++)
      if (arbit_grant[j]) w_busy_nxt[arbit_addr[j]] = 1'b0;
    for (int unsigned i = 0; i < DECODE_NUM; i++)
      if (free_valid[i]) w_busy_nxt[free_addr[i]] = 1'b1;
    if (w_accept) w_age_nxt = r_age_cnt + AGE'(w_req_cnt);
    if (flush) begin
      w_busy_nxt = '0;
      w_age_nxt  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy    <= '0;
      r_age_cnt <= '0;
    end else begin
      r_busy    <= w_busy_nxt;
      r_age_cnt <= w_age_nxt;
    end
  end

  always_comb begin
    iq_count = '0;
    for (int unsigned e = 0; e < CIQ_DEPTH; e++)
      iq_count = iq_count + CW'(r_busy[e]);
    iq_full  = (iq_count == CW'(CIQ_DEPTH));
    iq_empty = (iq_count == '0);
  end

endmodule

// File: tb/tb_issue_queue_alloc_ctrl.sv
// Bench for issue_queue_alloc_ctrl: free-list model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_issue_queue_alloc_ctrl;
  localparam int DN = 4;
  localparam int IN = 4;
  localparam int DEPTH = 16;
  localparam int AW = 5;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [DN-1:0]        dispatch_req;
  logic                 flush;
  logic [IN-1:0][3:0]   arbit_addr;
  logic [IN-1:0]        arbit_grant;
  logic [DN-1:0][3:0]   free_addr;
  logic [DN-1:0]        free_valid;
  logic [DN-1:0][AW-1:0] age;
  logic                 dispatch_stall;
  logic [4:0]           iq_count;
  logic                 iq_full;
  logic                 iq_empty;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  bit [DEPTH-1:0] m_busy = '0;
  int m_age = 0;

  always #5 clk = ~clk;

  issue_queue_alloc_ctrl #(
    .DECODE_NUM (DN),
    .ISSUE_NUM  (IN),
    .CIQ_DEPTH  (DEPTH),
    .AGE        (AW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .dispatch_req   (dispatch_req),
    .flush          (flush),
    .arbit_addr     (arbit_addr),
    .arbit_grant    (arbit_grant),
    .free_addr      (free_addr),
    .free_valid     (free_valid),
    .age            (age),
    .dispatch_stall (dispatch_stall),
    .iq_count       (iq_count),
    .iq_full        (iq_full),
    .iq_empty       (iq_empty)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction

  function automatic int nth_free(input bit [DEPTH-1:0] b, input int n);
    int seen = 0;
    for (int e = 0; e < DEPTH; e++) begin
      if (!b[e]) begin
        if (seen == n) return e;
        seen++;
      end
    end
    return -1;
  endfunction

  // model state: the set of busy entries and the running age counter
  always @(posedge clk or negedge rst_n) begin : model
    bit [DEPTH-1:0] nb;
    int nreq;
    if (!rst_n) begin
      m_busy = '0;
      m_age  = 0;
    end else if (flush) begin
      m_busy = '0;
      m_age  = 0;
    end else begin
      nreq = $countones(dispatch_req);
      nb = m_busy;
      for (int j = 0; j < IN; j++)
        if (arbit_grant[j]) nb[arbit_addr[j]] = 1'b0;
      if (nreq <= DEPTH - $countones(m_busy)) begin
        for (int k = 0; k < nreq; k++) nb[nth_free(m_busy, k)] = 1'b1;
        m_age = (m_age + nreq) % 32;
      end
      m_busy = nb;
    end
  end

  always @(negedge clk) begin : compare
    int nreq;
    int k;
    bit acc;
    if (chk_en) begin
      nreq = $countones(dispatch_req);
      acc = rst_n && !flush && (nreq <= DEPTH - $countones(m_busy));
      chk("stall", dispatch_stall, flush || (nreq > 0 && !acc));
      k = 0;
      for (int i = 0; i < DN; i++) begin
        chk("valid", free_valid[i], acc && dispatch_req[i]);
        if (acc && dispatch_req[i]) begin
          chk("addr", free_addr[i], nth_free(m_busy, k));
          chk("age", age[i], (m_age + k) % 32);
          k++;
        end
      end
      chk("count", iq_count, $countones(m_busy));
      chk("full", iq_full, $countones(m_busy) == DEPTH);
      chk("empty", iq_empty, $countones(m_busy) == 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; dispatch_req = 4'b1111;
    arbit_grant = '0; arbit_addr = '0; chk_en = 1'b1;
    #3;
    chk("rst_count", iq_count, 0);
    chk("rst_empty", iq_empty, 1);
    chk("rst_full", iq_full, 0);
    chk("rst_valid", free_valid, 0);
    step(); step();
    rst_n = 1'b1;
    #2;
    chk("first_addr", free_addr, 16'h3210);
    chk("first_valid", free_valid, 4'b1111);
    chk("first_age", age, {5'd3, 5'd2, 5'd1, 5'd0});
    step(); dispatch_req = 4'b0000; #2;
    chk("first_count", iq_count, 4);

    // fill to 14 entries, then an oversize request must stall
    dispatch_req = 4'b1111; step(); step();
    dispatch_req = 4'b0011; step();
    dispatch_req = 4'b0111; #2;
    chk("over_stall", dispatch_stall, 1);
    chk("over_valid", free_valid, 0);
    step(); dispatch_req = 4'b0000; #2;
    chk("over_count", iq_count, 14);
    dispatch_req = 4'b0011; #2;
    chk("fill_addr0", free_addr[0], 14);
    chk("fill_addr1", free_addr[1], 15);
    step(); dispatch_req = 4'b0000; #2;
    chk("fill_full", iq_full, 1);

    // releases are not reusable in the cycle they are granted
    arbit_addr[0] = 4'd3; arbit_addr[1] = 4'd9; arbit_grant = 4'b0011;
    dispatch_req = 4'b0001; #2;
    chk("rel_stall", dispatch_stall, 1);
    chk("rel_valid", free_valid, 0);
    step(); arbit_grant = '0; #2;
    chk("reuse_valid", free_valid, 4'b0001);
    chk("reuse_addr", free_addr[0], 3);
    chk("reuse_age", age[0], 16);
    step(); dispatch_req = 4'b0000; #2;
    chk("reuse_count", iq_count, 15);

    // duplicate grants and a grant to an already-free entry
    arbit_addr[0] = 4'd2; arbit_addr[1] = 4'd2; arbit_addr[2] = 4'd9;
    arbit_grant = 4'b0111;
    step(); arbit_grant = '0; #2;
    chk("dup_count", iq_count, 14);

    // flush overrides dispatch and grants
    flush = 1'b1; dispatch_req = 4'b1111;
    arbit_addr[0] = 4'd0; arbit_addr[1] = 4'd1; arbit_grant = 4'b0011; #2;
    chk("flush_valid", free_valid, 0);
    chk("flush_stall", dispatch_stall, 1);
    step(); flush = 1'b0; arbit_grant = '0; dispatch_req = 4'b0000; #2;
    chk("flush_empty", iq_empty, 1);
    dispatch_req = 4'b0001; #2;
    chk("flush_age", age[0], 0);
    chk("flush_addr", free_addr[0], 0);
    step(); dispatch_req = 4'b0000;
    arbit_addr = '0; arbit_grant = 4'b0001;
    step(); arbit_grant = '0;

    // run the age counter up to 30, then wrap it
    for (int r = 0; r < 7; r++) begin
      dispatch_req = 4'b1111; step();
      dispatch_req = 4'b0000;
      arbit_addr = {4'd3, 4'd2, 4'd1, 4'd0}; arbit_grant = 4'b1111;
      step(); arbit_grant = '0;
    end
    dispatch_req = 4'b0001; step();
    dispatch_req = 4'b1011; #2;
    chk("wrap_age0", age[0], 30);
    chk("wrap_age1", age[1], 31);
    chk("wrap_age3", age[3], 0);
    chk("wrap_addr3", free_addr[3], 3);
    step(); dispatch_req = 4'b0001; #2;
    chk("wrap_next_age", age[0], 1);
    chk("wrap_next_addr", free_addr[0], 4);
    step(); dispatch_req = 4'b0011; step();
    dispatch_req = 4'b0000; #1;
    chk("pre_rst_count", iq_count, 7);

    // asynchronous reset between clock edges
    #1; rst_n = 1'b0; dispatch_req = 4'b1111; #1;
    chk("async_count", iq_count, 0);
    chk("async_empty", iq_empty, 1);
    chk("async_full", iq_full, 0);
    chk("async_valid", free_valid, 0);
    step(); rst_n = 1'b1; dispatch_req = 4'b0000;
    step(); step();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
